gpio_port: RTL
==============

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 6, is the number of port pins (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the input synchroniser depth (legal range 2..4).
REQ-003 Clocking and reset are fixed: one clock, `clk`, and an asynchronous, active-low reset, `rst_n`.
REQ-004 Ports SHALL be as follows (clock and reset first):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  vcc  in  1  supply-present indication
  gnd  in  1  ground-reference indication; power_good = vcc & ~gnd
  pad_in  in  WIDTH  asynchronous pin levels
  pad_out  out  WIDTH  driven pin levels
  pad_oe  out  WIDTH  per-pin output enable
  addr  in  2  register select: 0=PIN, 1=DDR, 2=PORT, 3=PCMSK
  wr_en  in  1  register write strobe
  wr_data  in  WIDTH  write data
  rd_data  out  WIDTH  read data
  pcif_clr  in  1  clear pin-change flag
  pcint_irq  out  1  pin-change interrupt request

Function
REQ-005 rd_data SHALL be combinational from addr: PIN returns the synchronised inputs; DDR, PORT and PCMSK return their registers.
REQ-006 A write to DDR, PORT or PCMSK (wr_en=1) SHALL load wr_data at the next rising edge.
REQ-007 A write to PIN SHALL toggle each PORT bit whose wr_data bit is 1 and leave the others unchanged.
REQ-008 The synchronised PIN value SHALL equal pad_in as sampled SYNC_STAGES rising edges earlier.
REQ-009 Every pin SHALL be synchronised, regardless of its DDR value.
REQ-010 Outputs when power_good=1: pad_oe = DDR and pad_out = PORT & DDR.
REQ-011 Outputs when power_good=0: pad_oe and pad_out SHALL be all-zero combinationally, and writes SHALL be ignored.
REQ-012 While power_good=0, registers SHALL retain their values and the synchroniser input SHALL be forced to zero.
REQ-013 A pin change SHALL be detected when the synchronised value differs from a one-cycle-delayed copy in any bit where PCMSK=1.
REQ-014 On a detected change, the sticky flag pcif SHALL set at the following edge; pcint_irq = pcif.
REQ-015 pcif_clr=1 SHALL clear pcif at the next edge.
REQ-016 If a set and pcif_clr occur in the same cycle, set SHALL win.
REQ-017 If PCMSK is written in the same cycle as a change, the old mask SHALL apply.
REQ-018 When power_good returns from 0 to 1, the delayed copy SHALL be reloaded from the synchroniser output for one cycle so that the reload cycle generates no spurious pcif.
REQ-019 A write to the PIN address SHALL not alter the synchroniser or pcif.

Reset
REQ-020 rst_n low SHALL asynchronously clear DDR, PORT, PCMSK, pcif, all synchroniser stages and the delayed copy.
REQ-021 During reset, pad_out=0, pad_oe=0, pcint_irq=0 and rd_data reads 0 for every address.
REQ-022 Reset release SHALL be sampled so that no register changes at the deasserting edge.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight synchronised edge and any pending flag.

Structure
REQ-024 A shared package gpio_pkg SHALL hold the register address constants (ADDR_PIN/DDR/PORT/PCMSK) and the WIDTH/SYNC_STAGES defaults.
REQ-025 One sub-module, gpio_sync, SHALL implement a WIDTH-wide, SYNC_STAGES-deep flop chain with async active-low reset.
REQ-026 Target size: 120-400 lines of RTL total.

Verification
REQ-027 Reset then read: rst_n pulse low -> rd_data=0 at all four addresses; pad_oe=0; pcint_irq=0.
REQ-028 Output drive: DDR=6'h03, PORT=6'h3F -> pad_oe=6'h03, pad_out=6'h03; PIN write 6'h01 -> PORT=6'h3E, pad_out=6'h02.
REQ-029 Input latency: pad_in 6'h00->6'h14 -> PIN reads 6'h14 exactly 2 edges later (SYNC_STAGES=2).
REQ-030 Pin change with mask: PCMSK=6'h04, toggle pad_in[2] -> pcint_irq=1 one edge after PIN changes; toggle pad_in[3] only -> no irq.
REQ-031 Flag arbitration: pcif_clr=1 in the same cycle as a new masked change -> pcint_irq remains 1; a later clear alone -> 0.
REQ-032 Power loss: vcc=0 with DDR=6'h3F and PORT=6'h3F -> pad_out=0 and pad_oe=0 immediately; a write is ignored; on vcc=1, outputs return to 6'h3F with no spurious irq.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register map and parameter defaults.
package gpio_pkg;

  localparam int DEFAULT_WIDTH       = 6;
  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic [1:0] ADDR_PIN   = 2'd0;
  localparam logic [1:0] ADDR_DDR   = 2'd1;
  localparam logic [1:0] ADDR_PORT  = 2'd2;
  localparam logic [1:0] ADDR_PCMSK = 2'd3;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain that brings asynchronous pad levels into the clk domain.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// GPIO port: PIN/DDR/PORT/PCMSK registers, synchronised inputs and a sticky
// pin-change interrupt, with outputs and writes gated by supply presence.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vcc,
  input  logic             gnd,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  input  logic             pcif_clr,
  output logic             pcint_irq
);

  logic             power_good;
  logic             pg_d;
  logic             rst_ok;
  logic             change;
  logic             pcif;
  logic [WIDTH-1:0] ddr;
  logic [WIDTH-1:0] port;
  logic [WIDTH-1:0] pcmsk;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_prev;

  assign power_good = vcc & ~gnd;
  assign sync_in    = (power_good && rst_ok) ? pad_in : '0;

  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sync_in),
    .q     (pin_sync)
  );

  // First edge after reset release only arms the block, so nothing else moves then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ok <= 1'b0;
    else        rst_ok <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr   <= '0;
      port  <= '0;
      pcmsk <= '0;
    end else if (rst_ok && power_good && wr_en) begin
      case (addr)
        ADDR_PIN:   port  <= port ^ wr_data;
        ADDR_DDR:   ddr   <= wr_data;
        ADDR_PORT:  port  <= wr_data;
        ADDR_PCMSK: pcmsk <= wr_data;
        default:    port  <= port;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_prev <= '0;
      pg_d     <= 1'b0;
    end else begin
      pin_prev <= pin_sync;
      pg_d     <= power_good;
    end
  end

  // pg_d low marks the reload cycle after power returns; no change is reported then.
  assign change = rst_ok && power_good && pg_d && (|((pin_sync ^ pin_prev) & pcmsk));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   pcif <= 1'b0;
    else if (change)                              pcif <= 1'b1;
    else if (rst_ok && power_good && pcif_clr)    pcif <= 1'b0;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_PIN:   rd_data = pin_sync;
      ADDR_DDR:   rd_data = ddr;
      ADDR_PORT:  rd_data = port;
      ADDR_PCMSK: rd_data = pcmsk;
      default:    rd_data = '0;
    endcase
  end

  assign pad_oe    = power_good ? ddr : '0;
  assign pad_out   = power_good ? (port & ddr) : '0;
  assign pcint_irq = pcif;

endmodule
